// File: rtl/div_iter.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU.
// Fixed 34-cycle latency from acceptance to the ready pulse.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  input  logic        flush,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] raw_q, raw_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rmd_q, rmd_d;
  logic        sgnq_q, sgnq_d;
  logic        sgnr_q, sgnr_d;
  logic        dz_q, dz_d;

  logic [32:0] shift;
  logic [31:0] sub;
  logic        ge;
  logic [31:0] abs1, abs2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (cnt_q == 5'd31) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // 33-bit shifted partial remainder; the true difference always fits 32 bits
  assign shift = {rem_q, dvd_q[31]};
  assign ge    = shift >= {1'b0, dvs_q};
  assign sub   = shift[31:0] - dvs_q;
  assign abs1  = (signed_div & opr1[31]) ? -opr1 : opr1;
  assign abs2  = (signed_div & opr2[31]) ? -opr2 : opr2;

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    raw_d  = raw_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    dz_d   = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          cnt_d  = '0;
          rem_d  = '0;
          dvd_d  = abs1;
          dvs_d  = abs2;
          raw_d  = opr1;
          sgnq_d = signed_div & (opr1[31] ^ opr2[31]);
          sgnr_d = signed_div & opr1[31];
          dz_d   = (opr2 == 32'd0);
        end
      end
      CALC: begin
        rem_d = ge ? sub : shift[31:0];
        dvd_d = {dvd_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
      end
      FIX: begin
        if (!flush) begin
          if (dz_q) begin
            quo_d = 32'hFFFF_FFFF;
            rmd_d = raw_q;
          end else begin
            quo_d = sgnq_q ? -dvd_q : dvd_q;
            rmd_d = sgnr_q ? -rem_q : rem_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready     = (state_q == DONE) && !flush;
    quotient  = quo_q;
    remainder = rmd_q;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle 32-bit integer divider serving the EX stage's `div_start` / `div_signed` / `div_ready` handshake. It accepts an operand pair and a signedness flag from the EX-stage ALU, and performs a radix-2 restoring division over 32 iterations. It returns the quotient and remainder, with a one-cycle `ready` pulse, to the HI/LO writeback path. EX holds the pipeline stalled, with operands stable, while `start` is high.

## Interface
Parameters: none (fixed 32-bit datapath).

Ports:
- `clk`  in  1  — single clock; everything is on the rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `start`  in  1  — division request. Driven as `!ready` by EX while a DIV/DIVU is in EX.
- `signed_div`  in  1  — 1 = DIV (two's complement), 0 = DIVU.
- `opr1`  in  32  — dividend.
- `opr2`  in  32  — divisor.
- `flush`  in  1  — pipeline flush (exception/eret). Abandons any operation in progress.
- `ready`  out  1  — one-cycle pulse; `quotient` and `remainder` are valid in that cycle.
- `quotient`  out  32  — registered result, goes to LO.
- `remainder`  out  32  — registered result, goes to HI.

## Operation
State machine: IDLE, CALC, FIX, DONE.
- **IDLE**:
  - If `start && !flush`, latch the operands and go to CALC. Iteration counter = 0, partial remainder (33-bit) = 0.
  - Latched values: `sgn_q = signed_div & (opr1[31]^opr2[31])` and `sgn_r = signed_div & opr1[31]`.
  - Dividend register = `|opr1|` if `signed_div` and negative, else `opr1`. Divisor register likewise, from `opr2`.
  - `start` is ignored in every state other than IDLE.
- **CALC**: one iteration per cycle.
  - Shift `{rem, dvd}` left by 1 and trial-subtract the divisor from `rem`.
  - If the difference is non-negative, `rem` = difference and the quotient bit = 1. Otherwise `rem` is kept and the quotient bit = 0.
  - The quotient bits are shifted into `dvd`.
  - Counter increments. After the 32nd iteration (counter == 31), go to FIX.
- **FIX**:
  - `quotient <= sgn_q ? -q : q`.
  - `remainder <= sgn_r ? -rem[31:0] : rem[31:0]`.
  - All negation is two's complement, truncated to 32 bits. Go to DONE.
- **DONE**: `ready` = 1 for this cycle only. Go to IDLE unconditionally.
- **Arithmetic rules**:
  - Absolute value of 0x80000000 is 0x80000000, treated as unsigned 2^31.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no exception.
- **Divide by zero** (`opr2 == 0`), both signednesses:
  - Uses the same state sequence and latency.
  - Result is forced in FIX: `quotient` = 0xFFFFFFFF, `remainder` = `opr1` as latched (original, not absolute).
- **Flush**:
  - In any state, `flush` = 1 sends the next state to IDLE. `ready` stays 0 and `quotient`/`remainder` keep their previous values.
  - `flush` has priority over `start` in IDLE.
- **Reset**:
  - `resetn` = 0 at an edge gives state IDLE, `ready` = 0, `quotient` = 0, `remainder` = 0, counter = 0, internal registers = 0.
  - Reset mid-CALC abandons the operation silently.

## Timing
- `start` sampled high in IDLE at edge T:
  - CALC occupies cycles T+1 … T+32.
  - FIX is cycle T+33.
  - DONE (`ready` = 1) is cycle T+34.
  - Fixed latency is 34 cycles after acceptance, independent of the operand values.
- `quotient`/`remainder` update at the FIX→DONE edge. They stay stable from DONE until the next FIX completes, so they remain readable after `ready` falls.
- `ready` is high for exactly one cycle. EX then drops `start` combinationally in that cycle, unstalls, and commits the result.
- Back-to-back: a new `start` can be accepted in the first IDLE cycle after DONE (T+35). There is no bubble beyond that IDLE cycle.
- `start` held high during CALC/FIX has no effect, and operand changes during CALC have no effect: the operands were latched at acceptance.

## Test plan
- **Unsigned**: DIVU 100 / 7, `start` at T → `ready` = 1 only at T+34, quotient = 14, remainder = 2. `ready` = 0 at T+33 and T+35.
- **Signed**: DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE (−2) → quotient 0xFFFFFFFD, remainder 1.
- **Corner cases**:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
  - DIV 5 / 0 → quotient 0xFFFFFFFF, remainder 5, `ready` at T+34.
- **Flush**: start 100/7 at T, `flush` at T+10 → no `ready` through T+40, outputs unchanged. Then start 9/4 at T+12 → `ready` at T+46, quotient 2, remainder 1.
- **Reset mid-operation**: `resetn` = 0 at T+20 for one cycle → `ready`, `quotient`, `remainder` all 0 next cycle. A fresh start afterwards completes normally in 34 cycles.
- **Back-to-back**: 100/7 then 0xFFFFFFF9/2 (signed), second `start` held by the bench as `!ready` → `ready` pulses at T+34 and T+69 with the correct results. Randomized 10k-pair comparison against a reference model covers both signednesses.
